// File: rtl/fixed_decoder_order4.sv
// Fixed order-4 LPC decoder: warm-up samples pass through, later beats are residuals added to the predictor.
// Optional feature: define FIXED_DEC_CHECKSUM_EN to add the oChecksum running-sum output.
module fixed_decoder_order4 #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [COUNT_W-1:0]  iBlockSize,
    input  logic                iValid,
    input  logic [SAMPLE_W-1:0] iResidual,
    output logic                oReady,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oDone
`ifdef FIXED_DEC_CHECKSUM_EN
    ,
    output logic [SAMPLE_W-1:0] oChecksum
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [COUNT_W-1:0]  r_size;
    logic [COUNT_W-1:0]  r_count;
    logic [SAMPLE_W-1:0] r_h1, r_h2, r_h3, r_h4;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;
    logic                r_done;

    logic                w_start;
    logic                w_beat;
    logic                w_last;
    logic [COUNT_W-1:0]  w_count_inc;
    logic [SAMPLE_W-1:0] w_pred;
    logic [SAMPLE_W-1:0] w_new;

    assign oReady      = (r_state != IDLE);
    assign w_start     = iStart && (iBlockSize != '0);
    assign w_beat      = iValid && oReady && !iStart;
    assign w_count_inc = r_count + 1'b1;
    assign w_last      = (w_count_inc == r_size);

    // 4h1 - 6h2 + 4h3 - h4 + r, wrapping at SAMPLE_W bits to mirror the encoder exactly
    assign w_pred = (r_h1 << 2) - (r_h2 << 2) - (r_h2 << 1) + (r_h3 << 2) - r_h4 + iResidual;
    assign w_new  = (r_state == WARMUP) ? iResidual : w_pred;

    always_ff @(posedge iClock) begin
        if (!iReset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = WARMUP;
        end else if (w_beat) begin
            case (r_state)
                WARMUP: begin
                    if (w_last)                         w_state_next = IDLE;
                    else if (r_count == COUNT_W'(3))    w_state_next = DECODE;
                end
                DECODE: begin
                    if (w_last) w_state_next = IDLE;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            r_size   <= '0;
            r_count  <= '0;
            r_h1     <= '0;
            r_h2     <= '0;
            r_h3     <= '0;
            r_h4     <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (w_start) begin
                r_size  <= iBlockSize;
                r_count <= '0;
                r_h1    <= '0;
                r_h2    <= '0;
                r_h3    <= '0;
                r_h4    <= '0;
            end else if (w_beat) begin
                r_sample <= w_new;
                r_valid  <= 1'b1;
                r_done   <= w_last;
                r_count  <= w_count_inc;
                r_h4     <= r_h3;
                r_h3     <= r_h2;
                r_h2     <= r_h1;
                r_h1     <= w_new;
            end
        end
    end

    assign oSample = r_sample;
    assign oValid  = r_valid;
    assign oDone   = r_done;

`ifdef FIXED_DEC_CHECKSUM_EN
    logic [SAMPLE_W-1:0] r_checksum;

    always_ff @(posedge iClock) begin
        if (!iReset)      r_checksum <= '0;
        else if (w_start) r_checksum <= '0;
        else if (w_beat)  r_checksum <= r_checksum + w_new;
    end

    assign oChecksum = r_checksum;
`endif

endmodule

// File: tb/tb_fixed_decoder_order4.sv
// Directed-vector bench for fixed_decoder_order4; checksum checks run only with FIXED_DEC_CHECKSUM_EN.
module tb_fixed_decoder_order4;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iStart = 1'b0;
    logic [15:0] iBlockSize = '0;
    logic        iValid = 1'b0;
    logic [15:0] iResidual = '0;
    logic        oReady;
    logic [15:0] oSample;
    logic        oValid;
    logic        oDone;
`ifdef FIXED_DEC_CHECKSUM_EN
    logic [15:0] oChecksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fixed_decoder_order4 #(.SAMPLE_W(16), .COUNT_W(16)) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iStart     (iStart),
        .iBlockSize (iBlockSize),
        .iValid     (iValid),
        .iResidual  (iResidual),
        .oReady     (oReady),
        .oSample    (oSample),
        .oValid     (oValid),
        .oDone      (oDone)
`ifdef FIXED_DEC_CHECKSUM_EN
        ,
        .oChecksum  (oChecksum)
`endif
    );

    always #5 iClock = ~iClock;

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic start_block(input logic [15:0] size);
        iStart = 1'b1; iBlockSize = size; iValid = 1'b0;
        step();
        iStart = 1'b0;
    endtask

    task automatic test_reset();
        iReset = 1'b0; iValid = 1'b1; iResidual = 16'd55;
        step(); step();
        n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", oValid); end
        n_cmp++; if (oDone !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", oDone); end
        n_cmp++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", oReady); end
        n_cmp++; if (oSample !== 16'd0) begin n_bad++; $display("FAIL reset_sample got=%0d want=0", oSample); end
        iReset = 1'b1;
        step();
        n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL idle_beat_ignored got=%b want=0", oValid); end
        iValid = 1'b0;
    endtask

    task automatic test_decode8();
        logic [15:0] beats [8] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [15:0] exp   [8] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700, 16'd800};
        start_block(16'd8);
        n_cmp++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL d8_ready got=%b want=1", oReady); end
        for (int i = 0; i < 8; i++) begin
            iValid = 1'b1; iResidual = beats[i];
            step();
            n_cmp++; if (oValid !== 1'b1 || oSample !== exp[i] || oDone !== (i == 7))
                begin n_bad++; $display("FAIL d8_beat%0d got v=%b s=%0d d=%b want v=1 s=%0d d=%b", i, oValid, oSample, oDone, exp[i], (i == 7)); end
        end
        n_cmp++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL d8_ready_after got=%b want=0", oReady); end
`ifdef FIXED_DEC_CHECKSUM_EN
        n_cmp++; if (oChecksum !== 16'd3600) begin n_bad++; $display("FAIL d8_checksum got=%0d want=3600", oChecksum); end
`endif
        iValid = 1'b0;
        step();
        n_cmp++; if (oValid !== 1'b0 || oDone !== 1'b0 || oSample !== 16'd800)
            begin n_bad++; $display("FAIL d8_hold got v=%b d=%b s=%0d want v=0 d=0 s=800", oValid, oDone, oSample); end
    endtask

    task automatic test_size5();
        start_block(16'd5);
        for (int i = 0; i < 4; i++) begin
            iValid = 1'b1; iResidual = 16'd1000;
            step();
            n_cmp++; if (oSample !== 16'd1000 || oDone !== 1'b0)
                begin n_bad++; $display("FAIL s5_warm%0d got s=%0d d=%b want s=1000 d=0", i, oSample, oDone); end
        end
        iResidual = 16'd5;
        step();
        n_cmp++; if (oValid !== 1'b1 || oSample !== 16'd1005 || oDone !== 1'b1)
            begin n_bad++; $display("FAIL s5_last got v=%b s=%0d d=%b want v=1 s=1005 d=1", oValid, oSample, oDone); end
        iValid = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        start_block(16'd5);
        iValid = 1'b1; iResidual = 16'd32767;
        repeat (4) step();
        iResidual = 16'd1;
        step();
        n_cmp++; if (oSample !== 16'h8000 || oDone !== 1'b1)
            begin n_bad++; $display("FAIL wrap got s=%h d=%b want s=8000 d=1", oSample, oDone); end
        iValid = 1'b0;
        step();
    endtask

    task automatic test_short_block();
        start_block(16'd3);
        for (int i = 0; i < 3; i++) begin
            iValid = 1'b1; iResidual = 16'(7 + i);
            step();
            n_cmp++; if (oValid !== 1'b1 || oSample !== 16'(7 + i) || oDone !== (i == 2))
                begin n_bad++; $display("FAIL s3_beat%0d got v=%b s=%0d d=%b want v=1 s=%0d d=%b", i, oValid, oSample, oDone, 7 + i, (i == 2)); end
        end
        n_cmp++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL s3_ready got=%b want=0", oReady); end
        iResidual = 16'd10;
        step();
        n_cmp++; if (oValid !== 1'b0 || oSample !== 16'd9)
            begin n_bad++; $display("FAIL s3_extra got v=%b s=%0d want v=0 s=9", oValid, oSample); end
        iValid = 1'b0;
    endtask

    task automatic test_restart_mid();
        logic [15:0] beats [6] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd0, 16'd0};
        start_block(16'd8);
        for (int i = 0; i < 6; i++) begin
            iValid = 1'b1; iResidual = beats[i];
            step();
        end
        n_cmp++; if (oSample !== 16'd600) begin n_bad++; $display("FAIL rs_pre got=%0d want=600", oSample); end
        iStart = 1'b1; iBlockSize = 16'd8; iValid = 1'b1; iResidual = 16'd999;
        step();
        iStart = 1'b0;
        n_cmp++; if (oValid !== 1'b0 || oReady !== 1'b1)
            begin n_bad++; $display("FAIL rs_drop got v=%b r=%b want v=0 r=1", oValid, oReady); end
`ifdef FIXED_DEC_CHECKSUM_EN
        n_cmp++; if (oChecksum !== 16'd0) begin n_bad++; $display("FAIL rs_checksum_clr got=%0d want=0", oChecksum); end
`endif
        for (int i = 0; i < 4; i++) begin
            iResidual = 16'(11 * (i + 1));
            step();
            n_cmp++; if (oValid !== 1'b1 || oSample !== 16'(11 * (i + 1)) || oDone !== 1'b0)
                begin n_bad++; $display("FAIL rs_warm%0d got v=%b s=%0d d=%b want v=1 s=%0d d=0", i, oValid, oSample, oDone, 11 * (i + 1)); end
        end
`ifdef FIXED_DEC_CHECKSUM_EN
        n_cmp++; if (oChecksum !== 16'd110) begin n_bad++; $display("FAIL rs_checksum got=%0d want=110", oChecksum); end
`endif
        iValid = 1'b0;
    endtask

    task automatic test_checksum_clear();
`ifdef FIXED_DEC_CHECKSUM_EN
        logic [15:0] beats [8] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd0, 16'd0, 16'd0, 16'd0};
        start_block(16'd8);
        for (int i = 0; i < 8; i++) begin
            iValid = 1'b1; iResidual = beats[i];
            step();
        end
        iValid = 1'b0;
        step();
        n_cmp++; if (oChecksum !== 16'd3600) begin n_bad++; $display("FAIL ck_hold got=%0d want=3600", oChecksum); end
        start_block(16'd4);
        n_cmp++; if (oChecksum !== 16'd0) begin n_bad++; $display("FAIL ck_clear got=%0d want=0", oChecksum); end
`endif
    endtask

    task automatic test_reset_mid_block();
        start_block(16'd8);
        iValid = 1'b1; iResidual = 16'd42;
        step(); step();
        iReset = 1'b0;
        step();
        n_cmp++; if (oValid !== 1'b0 || oReady !== 1'b0 || oSample !== 16'd0 || oDone !== 1'b0)
            begin n_bad++; $display("FAIL rst_mid got v=%b r=%b s=%0d d=%b want all 0", oValid, oReady, oSample, oDone); end
`ifdef FIXED_DEC_CHECKSUM_EN
        n_cmp++; if (oChecksum !== 16'd0) begin n_bad++; $display("FAIL rst_mid_checksum got=%0d want=0", oChecksum); end
`endif
        iReset = 1'b1;
        step();
        n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle got v=%b want 0", oValid); end
        iValid = 1'b0;
    endtask

    task automatic test_zero_size();
        start_block(16'd0);
        n_cmp++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL zero_size_ready got=%b want=0", oReady); end
    endtask

    initial begin
        test_reset();
        test_zero_size();
        test_decode8();
        test_size5();
        test_wrap();
        test_short_block();
        test_restart_mid();
        test_checksum_clear();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
